icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter: LINES, 64, number of direct-mapped lines (power of two, >= 2).
REQ-002 Parameter: LINE_WORDS, 4, 32-bit words per line (power of two, >= 2).
REQ-003 Port: i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: i_rst  input  1  reset, synchronous, active-high.
REQ-005 Port: i_addr  input  32  CPU fetch address (core's o_addr_i); bits [1:0] ignored.
REQ-006 Port: i_flush  input  1  invalidate all lines (fence.i).
REQ-007 Port: o_data  output  32  instruction word for i_addr (core's i_data_in_i).
REQ-008 Port: o_valid  output  1  o_data valid this cycle (core's i_valid_i).
REQ-009 Port: o_mem_addr  output  32  word-aligned refill address to backing memory.
REQ-010 Port: o_mem_rd  output  1  refill read request.
REQ-011 Port: i_mem_data  input  32  refill read data.
REQ-012 Port: i_mem_valid  input  1  i_mem_data valid; completes the outstanding request.

Function
REQ-013 Address split: offset = i_addr[log2(LINE_WORDS)+1:2], index = next log2(LINES) bits, tag = remaining upper bits.
REQ-014 Storage: per line one valid bit, one tag, LINE_WORDS data words; data and tag read asynchronously (combinational) by index.
REQ-015 States: IDLE, REFILL; exactly one active.
REQ-016 IDLE hit (valid[index] and tag match): o_valid=1, o_data=word[index][offset] in the same cycle, zero-cycle latency, no state change.
REQ-017 IDLE miss: o_valid=0; next edge latches line base (i_addr with offset and [1:0] zeroed), clears word counter, enters REFILL.
REQ-018 o_valid SHALL be 0 in every cycle spent in REFILL.
REQ-019 REFILL: o_mem_rd=1, o_mem_addr=latched base + 4*counter; address and o_mem_rd held stable until i_mem_valid.
REQ-020 REFILL, i_mem_valid=1: i_mem_data written to word[counter] of latched index; counter increments; i_mem_valid ignored whenever o_mem_rd=0.
REQ-021 Last word (counter = LINE_WORDS-1) accepted: tag written, valid set, state returns to IDLE; o_mem_rd=0 the following cycle; re-lookup hits one cycle after refill end.
REQ-022 Refill uses the latched index/tag only; i_addr changes during REFILL do not alter the refill in progress.
REQ-023 Critical word is not forwarded; words always fetched in order 0..LINE_WORDS-1.
REQ-024 i_flush in IDLE: all valid bits cleared on that edge; o_valid=0 in the flush cycle.
REQ-025 i_flush in REFILL: refill continues to completion but the line is NOT marked valid; all other valid bits cleared on the flush edge.
REQ-026 Flush and last-word acceptance on the same edge: flush wins, line left invalid.
REQ-027 o_mem_addr SHALL be 0 whenever o_mem_rd=0.
REQ-028 Address arithmetic modulo 2^32; a line at 0xFFFFFFF0 refills words 0xFFFFFFF0..0xFFFFFFFC without carry into tag.

Reset
REQ-029 i_rst=1 on an edge: state IDLE, all valid bits 0, counter 0, latched base 0; takes priority over flush and i_mem_valid.
REQ-030 Outputs after reset: o_valid=0 (first access misses), o_mem_rd=0, o_mem_addr=0; o_data undefined while o_valid=0.
REQ-031 Reset mid-refill abandons the refill; line stays invalid; a late i_mem_valid after reset is ignored.
REQ-032 Data and tag arrays need not be reset.

Verification
REQ-033 Cold miss: reset, i_addr=0x00000104, memory returns 0xA0..0xA3 at 0x100..0x10C with 2-cycle latency each -> o_mem_addr 0x100,0x104,0x108,0x10C in order, then o_valid=1, o_data=0xA1.
REQ-034 Hit: after REQ-033, i_addr=0x10C -> o_valid=1, o_data=0xA3 same cycle, o_mem_rd stays 0.
REQ-035 Conflict: (LINES=64, LINE_WORDS=4) i_addr=0x00000500 after 0x100 loaded -> miss, refill 0x500..0x50C; subsequent 0x100 misses again.
REQ-036 Flush during refill: assert i_flush while refilling 0x200 -> refill completes (4 reads), next access 0x200 misses and refills again; 0x100 also misses.
REQ-037 Reset mid-refill: i_rst after 2 of 4 words -> o_mem_rd=0 next cycle, i_mem_valid pulse ignored, 0x100 access restarts refill at word 0.
REQ-038 Address change during refill: i_addr moved 0x100 -> 0x300 mid-refill -> line 0x100 finishes and validates, then 0x300 refill starts.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped instruction cache with in-order line refill from a single-beat memory port.
// Hits return data combinationally; misses stall o_valid until the whole line is loaded.
module icache #(
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_addr,
  input  logic        i_flush,
  output logic [31:0] o_data,
  output logic        o_valid,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_rd,
  input  logic [31:0] i_mem_data,
  input  logic        i_mem_valid
);

  localparam int OFF_W   = $clog2(LINE_WORDS);
  localparam int IDX_W   = $clog2(LINES);
  localparam int TAG_LSB = 2 + OFF_W + IDX_W;
  localparam int TAG_W   = 32 - TAG_LSB;
  localparam int LINE_W  = 30 - OFF_W;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t state, state_nxt;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags  [LINES];
  logic [31:0]      words [LINES*LINE_WORDS];

  logic [LINE_W-1:0] line_q;
  logic [OFF_W-1:0]  cnt;
  logic              flushed;

  logic [OFF_W-1:0] offset;
  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] fill_index;
  logic [TAG_W-1:0] fill_tag;
  logic             hit;
  logic             last;
  logic             word_we;
  logic             start_fill;
  logic             unused_addr;

  assign offset      = i_addr[OFF_W+1:2];
  assign index       = i_addr[TAG_LSB-1:OFF_W+2];
  assign tag         = i_addr[31:TAG_LSB];
  assign fill_index  = line_q[IDX_W-1:0];
  assign fill_tag    = line_q[LINE_W-1:IDX_W];
  assign unused_addr = ^i_addr[1:0];

  assign hit        = valid[index] && (tags[index] == tag);
  assign last       = (cnt == OFF_W'(LINE_WORDS - 1));
  assign word_we    = (state == REFILL) && i_mem_valid;
  assign start_fill = (state == IDLE) && (state_nxt == REFILL);

  assign o_data = words[{index, offset}];

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // A flush cycle in IDLE never starts a refill; the following cycle re-evaluates the miss.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!i_flush && !hit)     state_nxt = REFILL;
      REFILL:  if (i_mem_valid && last)  state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_valid    = 1'b0;
    o_mem_rd   = 1'b0;
    o_mem_addr = '0;
    case (state)
      IDLE: o_valid = hit && !i_flush;
      REFILL: begin
        o_mem_rd   = 1'b1;
        o_mem_addr = {line_q, cnt, 2'b00};
      end
      default: ;
    endcase
  end

  // Flush is applied last so it overrides the valid set on a coincident final beat.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid   <= '0;
      cnt     <= '0;
      line_q  <= '0;
      flushed <= 1'b0;
    end else begin
      if (start_fill) begin
        line_q       <= i_addr[31:OFF_W+2];
        cnt          <= '0;
        flushed      <= 1'b0;
        valid[index] <= 1'b0;
      end
      if (word_we) begin
        cnt <= cnt + 1'b1;
        if (last) valid[fill_index] <= !flushed;
      end
      if (i_flush) begin
        valid <= '0;
        if (state == REFILL) flushed <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && word_we) begin
      words[{fill_index, cnt}] <= i_mem_data;
      if (last) tags[fill_index] <= fill_tag;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: stimulus pushes expected refill addresses and fetch data into
// queues; a memory responder and an output monitor pop and compare independently.
module tb_icache;

  logic        clk;
  logic        i_rst;
  logic [31:0] i_addr;
  logic        i_flush;
  logic [31:0] o_data;
  logic        o_valid;
  logic [31:0] o_mem_addr;
  logic        o_mem_rd;
  logic [31:0] i_mem_data;
  logic        i_mem_valid;

  logic        resp_valid;
  logic [31:0] resp_data;
  logic        manual_valid;
  logic [31:0] manual_data;

  assign i_mem_valid = resp_valid | manual_valid;
  assign i_mem_data  = resp_valid ? resp_data : manual_data;

  icache #(.LINES(64), .LINE_WORDS(4)) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_addr     (i_addr),
    .i_flush    (i_flush),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_mem_addr (o_mem_addr),
    .o_mem_rd   (o_mem_rd),
    .i_mem_data (i_mem_data),
    .i_mem_valid(i_mem_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int beats = 0;
  int beat_stop = -1;
  int phase = 0;
  logic run = 1'b0;
  logic fetch_req = 1'b0;
  logic fetch_done = 1'b0;
  logic [31:0] req_addr;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];

  // Backing memory: line 0x100 holds 0xA0..0xA3, everything else holds ~address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h0000010) return 32'h000000A0 + {30'd0, a[3:2]};
    return ~a;
  endfunction

  task automatic push_line(input logic [31:0] a);
    for (int w = 0; w < 4; w++) exp_addr.push_back({a[31:4], 4'h0} + 32'(4 * w));
  endtask

  // Memory responder: one idle cycle after a request is seen, data is presented for one cycle.
  initial begin
    resp_valid = 1'b0;
    resp_data  = '0;
    forever begin
      @(negedge clk);
      if (phase == 1) begin
        checks++;
        if (!(o_mem_rd && o_mem_addr == req_addr)) begin
          errors++;
          $display("FAIL mem_hold: rd=%0b addr=%h required rd=1 addr=%h", o_mem_rd, o_mem_addr, req_addr);
        end
        resp_data  = mem_word(req_addr);
        resp_valid = 1'b1;
        phase      = 2;
      end else begin
        if (phase == 2) begin
          resp_valid = 1'b0;
          beats++;
          phase = 0;
        end
        if (run && o_mem_rd === 1'b1 && beats != beat_stop) begin
          checks++;
          if (exp_addr.size() == 0) begin
            errors++;
            $display("FAIL mem_unexpected: addr=%h required no request", o_mem_addr);
          end else begin
            req_addr = exp_addr.pop_front();
            if (o_mem_addr !== req_addr) begin
              errors++;
              $display("FAIL mem_addr: got %h required %h", o_mem_addr, req_addr);
            end
          end
          req_addr = o_mem_addr;
          phase    = 1;
        end
      end
    end
  end

  // Output monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (run) begin
        checks++;
        if (o_mem_rd !== 1'b1) begin
          if (o_mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL idle_mem_addr: got %h required 00000000", o_mem_addr);
          end
        end else if (o_valid !== 1'b0) begin
          errors++;
          $display("FAIL refill_valid: got %b required 0", o_valid);
        end
        if (fetch_req && !fetch_done && o_valid === 1'b1) begin
          checks++;
          if (exp_data.size() == 0) begin
            errors++;
            $display("FAIL data_unexpected: addr=%h data=%h", i_addr, o_data);
          end else if (o_data !== exp_data[0]) begin
            errors++;
            $display("FAIL fetch_data: addr=%h got %h required %h", i_addr, o_data, exp_data[0]);
            void'(exp_data.pop_front());
          end else begin
            void'(exp_data.pop_front());
          end
          fetch_done = 1'b1;
        end
      end
    end
  end

  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int nref, output int lat);
    for (int r = 0; r < nref; r++) push_line(a);
    exp_data.push_back(d);
    @(posedge clk);
    #1;
    i_addr     = a;
    fetch_done = 1'b0;
    fetch_req  = 1'b1;
    lat = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      #1;
      if (fetch_done) begin
        lat = n;
        break;
      end
    end
    fetch_req = 1'b0;
    checks++;
    if (lat < 0) begin
      errors++;
      $display("FAIL fetch_timeout: addr=%h got no o_valid required o_valid=1", a);
      exp_data.delete();
    end
    checks++;
    if (exp_addr.size() != 0) begin
      errors++;
      $display("FAIL refill_count: addr=%h got %0d reads outstanding required 0", a, exp_addr.size());
      exp_addr.delete();
    end
  endtask

  task automatic flush_at_word(input int w);
    int b0;
    b0 = beats;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      #1;
      if (resp_valid && beats == b0 + w) begin
        i_flush = 1'b1;
        @(negedge clk);
        #1;
        i_flush = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL flush_timeout: word %0d never presented required presented", w);
  endtask

  task automatic wait_beats(input int target, input string name);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      #1;
      if (beats >= target) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: got %0d beats required %0d", name, beats, target);
  endtask

  initial begin
    int lat;
    int b0;
    i_rst        = 1'b1;
    i_addr       = 32'h00000104;
    i_flush      = 1'b0;
    manual_valid = 1'b0;
    manual_data  = 32'h00000BAD;
    repeat (3) @(posedge clk);
    #1;
    i_rst = 1'b0;
    run   = 1'b1;
    push_line(32'h00000100);
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || o_mem_rd !== 1'b0 || o_mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b rd=%b addr=%h required 0 0 00000000", o_valid, o_mem_rd, o_mem_addr);
    end

    // Cold miss, then same-cycle hit.
    fetch(32'h00000104, 32'h000000A1, 0, lat);
    fetch(32'h0000010C, 32'h000000A3, 0, lat);
    checks++;
    if (lat != 0) begin
      errors++;
      $display("FAIL hit_latency: got %0d required 0", lat);
    end

    // Conflict on index 16.
    fetch(32'h00000500, 32'hFFFFFAFF, 1, lat);
    fetch(32'h00000100, 32'h000000A0, 1, lat);

    // Flush mid-refill: the line refills twice; the other line is gone too.
    fork
      flush_at_word(1);
      fetch(32'h00000200, 32'hFFFFFDFF, 2, lat);
    join
    fetch(32'h00000100, 32'h000000A0, 1, lat);

    // Flush coinciding with the last beat.
    fork
      flush_at_word(3);
      fetch(32'h00000240, 32'hFFFFFDBF, 2, lat);
    join

    // Flush in IDLE while hitting.
    push_line(32'h00000240);
    @(posedge clk);
    #1;
    i_flush = 1'b1;
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_cycle_valid: got %b required 0", o_valid);
    end
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    fetch(32'h00000240, 32'hFFFFFDBF, 0, lat);

    // Reset after two of four words.
    exp_addr.push_back(32'h00000100);
    exp_addr.push_back(32'h00000104);
    b0 = beats;
    beat_stop = b0 + 2;
    @(posedge clk);
    #1;
    i_addr = 32'h00000100;
    wait_beats(b0 + 2, "reset_wait");
    i_rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (o_mem_rd !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_refill_rd: got %b required 0", o_mem_rd);
    end
    i_rst        = 1'b0;
    manual_valid = 1'b1;
    @(negedge clk);
    #1;
    manual_valid = 1'b0;
    push_line(32'h00000100);
    beat_stop = -1;
    fetch(32'h00000100, 32'h000000A0, 0, lat);

    // Address moves mid-refill: the original line completes, then the new one.
    push_line(32'h00000140);
    push_line(32'h00000340);
    b0 = beats;
    @(posedge clk);
    #1;
    i_addr = 32'h00000140;
    wait_beats(b0 + 2, "addr_change_wait");
    i_addr = 32'h00000340;
    fetch(32'h00000340, 32'hFFFFFCBF, 0, lat);
    fetch(32'h00000140, 32'hFFFFFEBF, 0, lat);
    checks++;
    if (lat != 0) begin
      errors++;
      $display("FAIL first_line_kept: latency got %0d required 0", lat);
    end

    // Top of the address space.
    fetch(32'hFFFFFFFC, 32'h00000003, 1, lat);
    fetch(32'hFFFFFFF4, 32'h0000000B, 0, lat);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
